// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiply sequencer and control_mm:
// instruction encoding, FSM state encoding, dimension-word layout.
package mm_pkg;

    // Instruction codes understood by control_mm
    typedef enum logic [2:0] {
        INST_DIM = 3'd0,
        INST_LDA = 3'd1,
        INST_LDB = 3'd2,
        INST_STC = 3'd3,
        INST_MAC = 3'd4,
        INST_NOP = 3'd7
    } inst_e;

    // Sequencer states; each *_GAP / WAIT_* state supplies the NOP cycle after an issue
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DIM_RD,
        ST_DIM_WAIT,
        ST_DIM_WR,
        ST_DIM_GAP,
        ST_LD_A,
        ST_WAIT_A,
        ST_LD_B,
        ST_WAIT_B,
        ST_MAC,
        ST_MAC_GAP,
        ST_STORE,
        ST_ST_GAP,
        ST_DONE
    } state_e;

    localparam logic [31:0] DIM_ADDR = 32'h3C00;

    // Field positions of m, n, o inside the packed dimension word
    localparam int unsigned M_LSB = 0;
    localparam int unsigned N_LSB = 11;
    localparam int unsigned O_LSB = 22;

    // Block counts are carried at the width of the m*o product
    localparam int unsigned BLK_W = 22;

    // ceil(prod / 2**lanes_sh)
    function automatic logic [BLK_W-1:0] ceil_blocks(input logic [BLK_W-1:0] prod,
                                                    input int unsigned     lanes_sh);
        logic [BLK_W-1:0] mask;
        mask = (BLK_W'(1) << lanes_sh) - BLK_W'(1);
        return (prod >> lanes_sh) + (((prod & mask) != '0) ? BLK_W'(1) : '0);
    endfunction

endpackage

// File: rtl/mm_seq_lat_timer.sv
// Down-counter covering the data-memory read latency. Loaded on the issue
// cycle of a load; cnt_last marks the cycle read data is valid, expired marks
// the cycle the waiting state may leave.
module mm_seq_lat_timer #(
    parameter int unsigned LAT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic cnt_last,
    output logic expired
);

    logic [2:0] cnt_q;

    // Reload on issue, then count down to zero and hold
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= 3'd0;
        end else if (load) begin
            cnt_q <= 3'(LAT);
        end else if (cnt_q != 3'd0) begin
            cnt_q <= cnt_q - 3'd1;
        end
    end

    assign cnt_last = (cnt_q == 3'd1);
    assign expired  = (cnt_q == 3'd0);

endmodule

// File: rtl/mm_sequencer.sv
// Instruction sequencer for control_mm: loads the dimension word, then walks
// C output blocks issuing LD_A / LD_B / MAC per inner step and ST_C per block.
// Optional build macro MM_SEQ_PERF_EN enables the cycle_count run counter;
// without it cycle_count is tied to zero.
module mm_sequencer
    import mm_pkg::*;
#(
    parameter int unsigned LANES    = 8,
    parameter int unsigned DMEM_LAT = 1,
    parameter int unsigned DIM_W    = 11
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [255:0] dmem_rdata,
    input  logic         mm_complete,
    output logic [2:0]   inst,
    output logic         dim_we,
    output logic [255:0] dim,
    output logic         busy,
    output logic         done,
    output logic         seq_err,
    output logic [31:0]  cycle_count
);

    localparam int unsigned LANE_SH = $clog2(LANES);

    state_e             state;
    logic [31:0]        dim_q;
    logic [DIM_W-1:0]   k_q;
    logic [BLK_W-1:0]   blk_q;
    logic               last_q;   // final STORE of the run has been issued
    logic               early_q;  // mm_complete seen before the final STORE

    logic [DIM_W-1:0]   m, n, o;
    logic [BLK_W-1:0]   prod;
    logic [BLK_W-1:0]   total_blocks;
    logic               dim_zero;
    logic               start_acc;
    logic               lat_load, lat_last, lat_expired;
    logic               unused_rdata;

    assign m            = dim_q[M_LSB +: DIM_W];
    assign n            = dim_q[N_LSB +: DIM_W];
    assign o            = DIM_W'(dim_q[31:O_LSB]);
    assign prod         = BLK_W'(m) * BLK_W'(o);
    assign total_blocks = ceil_blocks(prod, LANE_SH);
    assign dim_zero     = (m == '0) || (n == '0) || (o == '0);
    assign start_acc    = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign dim          = {224'b0, dim_q};
    assign unused_rdata = ^dmem_rdata[255:32];

    assign lat_load = (state == ST_DIM_RD) || (state == ST_LD_A) || (state == ST_LD_B);

    mm_seq_lat_timer #(
        .LAT (DMEM_LAT)
    ) u_lat_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (lat_load),
        .cnt_last (lat_last),
        .expired  (lat_expired)
    );

    // Sequencer FSM; inst/dim_we/busy/done are registered alongside the state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            inst    <= INST_NOP;
            dim_we  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            seq_err <= 1'b0;
            dim_q   <= '0;
            k_q     <= '0;
            blk_q   <= '0;
            last_q  <= 1'b0;
            early_q <= 1'b0;
        end else begin
            inst   <= INST_NOP;
            dim_we <= 1'b0;
            if (busy && mm_complete && !last_q) begin
                early_q <= 1'b1;
            end
            case (state)
                ST_IDLE, ST_DONE: begin
                    // Zero-dimension runs issue no work, so there is nothing to reconcile
                    if ((state == ST_DONE) && !dim_zero && (!mm_complete || early_q)) begin
                        seq_err <= 1'b1;
                    end
                    if (start_acc) begin
                        state   <= ST_DIM_RD;
                        inst    <= INST_DIM;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        seq_err <= 1'b0;
                        k_q     <= '0;
                        blk_q   <= '0;
                        last_q  <= 1'b0;
                        early_q <= 1'b0;
                    end
                end
                ST_DIM_RD: state <= ST_DIM_WAIT;
                ST_DIM_WAIT: begin
                    if (lat_last) begin
                        dim_q <= dmem_rdata[31:0];
                    end
                    if (lat_expired) begin
                        state  <= ST_DIM_WR;
                        dim_we <= 1'b1;
                    end
                end
                ST_DIM_WR: state <= ST_DIM_GAP;
                ST_DIM_GAP: begin
                    if (dim_zero) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state <= ST_LD_A;
                        inst  <= INST_LDA;
                    end
                end
                ST_LD_A: state <= ST_WAIT_A;
                ST_WAIT_A: begin
                    if (lat_expired) begin
                        state <= ST_LD_B;
                        inst  <= INST_LDB;
                    end
                end
                ST_LD_B: state <= ST_WAIT_B;
                ST_WAIT_B: begin
                    if (lat_expired) begin
                        state <= ST_MAC;
                        inst  <= INST_MAC;
                    end
                end
                ST_MAC: begin
                    state <= ST_MAC_GAP;
                    k_q   <= k_q + DIM_W'(1);
                end
                ST_MAC_GAP: begin
                    if (k_q < n) begin
                        state <= ST_LD_A;
                        inst  <= INST_LDA;
                    end else begin
                        k_q   <= '0;
                        state <= ST_STORE;
                        inst  <= INST_STC;
                    end
                end
                ST_STORE: begin
                    state <= ST_ST_GAP;
                    blk_q <= blk_q + BLK_W'(1);
                    if ((blk_q + BLK_W'(1)) >= total_blocks) begin
                        last_q <= 1'b1;
                    end
                end
                ST_ST_GAP: begin
                    if (blk_q < total_blocks) begin
                        state <= ST_LD_A;
                        inst  <= INST_LDA;
                    end else begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef MM_SEQ_PERF_EN
    logic [31:0] cyc_q;

    // Run-length counter: restarts on accepted start, counts busy cycles, holds after
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc_q <= '0;
        end else if (start_acc) begin
            cyc_q <= '0;
        end else if (busy) begin
            cyc_q <= cyc_q + 32'd1;
        end
    end

    assign cycle_count = cyc_q;
`else
    assign cycle_count = '0;
`endif

endmodule
